bp_io_traffic_gen: RTL and testbench

Parametrised IO test engine for FPGA host bring-up. It has two independent halves:
- A burst generator that issues N uncached writes with incrementing data and a programmable address stride, with a bounded number of responses outstanding.
- A loopback responder that services incoming IO commands from a small scratch register file.

It sits between the FPGA host IO ports and board-level triggers, replacing single-byte putchar test logic.

---
 rtl/bp_io_traffic_gen.sv | 165 ++++++++++++++++
 tb/tb_bp_io_traffic_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bp_io_traffic_gen.sv
// IO test engine: a burst write generator with bounded outstanding responses,
// and an independent loopback responder backed by a small scratch register file.
module bp_io_traffic_gen
#(
    parameter int                      addr_width_p      = 40,
    parameter int                      data_width_p      = 64,
    parameter int                      burst_cnt_width_p = 16,
    parameter int                      max_outstanding_p = 4,
    parameter logic [addr_width_p-1:0] base_addr_p       = addr_width_p'(32'h0010_1000),
    parameter logic [addr_width_p-1:0] addr_stride_p     = '0,
    parameter logic [data_width_p-1:0] data_stride_p     = data_width_p'(1),
    parameter int                      scratch_els_p     = 8
)
(
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         start_i,
    input  logic [burst_cnt_width_p-1:0] burst_len_i,
    input  logic [data_width_p-1:0]      seed_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,

    output logic [addr_width_p-1:0]      cmd_addr_o,
    output logic [data_width_p-1:0]      cmd_data_o,
    output logic                         cmd_v_o,
    input  logic                         cmd_ready_and_i,
    input  logic                         resp_v_i,
    output logic                         resp_yumi_o,

    input  logic                         in_cmd_v_i,
    input  logic                         in_cmd_wr_i,
    input  logic [addr_width_p-1:0]      in_cmd_addr_i,
    input  logic [data_width_p-1:0]      in_cmd_data_i,
    output logic                         in_cmd_yumi_o,
    output logic                         in_resp_v_o,
    output logic [data_width_p-1:0]      in_resp_data_o,
    input  logic                         in_resp_ready_and_i
);

    localparam int out_w_lp = $clog2(max_outstanding_p + 1);
    localparam int idx_w_lp = $clog2(scratch_els_p);
    localparam int off_lp   = $clog2(data_width_p / 8);

    // ---------------- generator ----------------
    typedef enum logic [1:0] {e_idle, e_send, e_drain} state_e;

    state_e                       state_r, state_n;
    logic [burst_cnt_width_p-1:0] len_r, sent_r;
    logic [out_w_lp-1:0]          outst_r, outst_n;
    logic [addr_width_p-1:0]      addr_r;
    logic [data_width_p-1:0]      data_r;
    logic                         err_r, done_r;
    logic                         start_acc, cmd_hs, resp_ok, last_send;

    assign start_acc = start_i & (state_r == e_idle);
    assign cmd_hs    = cmd_v_o & cmd_ready_and_i;
    assign resp_ok   = resp_v_i & (outst_r != '0);
    assign last_send = cmd_hs & ((sent_r + burst_cnt_width_p'(1)) == len_r);

    // A handshake and a matched response in one cycle cancel out.
    always_comb begin
        outst_n = outst_r;
        if (cmd_hs & ~resp_ok)
            outst_n = outst_r + out_w_lp'(1);
        else if (~cmd_hs & resp_ok)
            outst_n = outst_r - out_w_lp'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle:  if (start_acc && burst_len_i != '0) state_n = e_send;
            e_send:  if (last_send)                      state_n = e_drain;
            e_drain: if (outst_n == '0)                  state_n = e_idle;
            default:                                     state_n = e_idle;
        endcase
    end

    always_comb begin
        cmd_v_o = 1'b0;
        busy_o  = 1'b0;
        unique case (state_r)
            e_send: begin
                busy_o  = 1'b1;
                cmd_v_o = (outst_r < out_w_lp'(max_outstanding_p));
            end
            e_drain: busy_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_r   <= '0;
            sent_r  <= '0;
            outst_r <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            outst_r <= outst_n;
            err_r   <= err_r | (resp_v_i & (outst_r == '0));
            done_r  <= ((state_r == e_drain) && (outst_n == '0))
                     | (start_acc && (burst_len_i == '0));
            if (start_acc) begin
                len_r  <= burst_len_i;
                sent_r <= '0;
                addr_r <= base_addr_p;
                data_r <= seed_data_i;
            end else if (cmd_hs) begin
                addr_r <= addr_r + addr_stride_p;
                data_r <= data_r + data_stride_p;
                sent_r <= sent_r + burst_cnt_width_p'(1);
            end
        end
    end

    assign cmd_addr_o  = addr_r;
    assign cmd_data_o  = data_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign resp_yumi_o = resp_v_i & ~reset_i;

    // ---------------- loopback responder ----------------
    typedef struct packed {
        logic                    v;
        logic [data_width_p-1:0] data;
    } lb_resp_s;

    lb_resp_s                                   lb_r;
    logic [scratch_els_p-1:0][data_width_p-1:0] scratch_r;
    logic [idx_w_lp-1:0]                        in_idx;
    logic                                       unused_addr;

    assign in_idx        = in_cmd_addr_i[off_lp +: idx_w_lp];
    assign unused_addr   = ^in_cmd_addr_i;
    assign in_cmd_yumi_o = in_cmd_v_i & (~lb_r.v | in_resp_ready_and_i) & ~reset_i;

    // Reads return the pre-update word; writes echo the written data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lb_r      <= '0;
            scratch_r <= '0;
        end else if (in_cmd_yumi_o) begin
            lb_r.v    <= 1'b1;
            lb_r.data <= in_cmd_wr_i ? in_cmd_data_i : scratch_r[in_idx];
            if (in_cmd_wr_i)
                scratch_r[in_idx] <= in_cmd_data_i;
        end else if (in_resp_ready_and_i) begin
            lb_r.v <= 1'b0;
        end
    end

    assign in_resp_v_o    = lb_r.v;
    assign in_resp_data_o = lb_r.data;

endmodule

// File: tb/tb_bp_io_traffic_gen.sv
// Directed bench: two generator instances (fixed and 8-byte stride) share stimulus;
// a small reference model tracks outstanding/sent/done/err per cycle.
module tb_bp_io_traffic_gen;

    localparam int          MAX  = 4;
    localparam logic [63:0] BASE = 64'h0010_1000;

    logic        clk = 1'b0, reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] burst_len_i = '0;
    logic [63:0] seed_data_i = '0;
    logic        cmd_ready_and_i = 1'b0, resp_v_i = 1'b0;
    logic        in_cmd_v_i = 1'b0, in_cmd_wr_i = 1'b0, in_resp_ready_and_i = 1'b0;
    logic [39:0] in_cmd_addr_i = '0;
    logic [63:0] in_cmd_data_i = '0;

    logic        busy_o, done_o, err_o, cmd_v_o, resp_yumi_o, in_cmd_yumi_o, in_resp_v_o;
    logic [39:0] cmd_addr_o;
    logic [63:0] cmd_data_o, in_resp_data_o;

    logic        busy_s, done_s, err_s, cmd_v_s, resp_yumi_s, in_cmd_yumi_s, in_resp_v_s;
    logic [39:0] cmd_addr_s;
    logic [63:0] cmd_data_s, in_resp_data_s;

    always #5 clk = ~clk;

    bp_io_traffic_gen dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .burst_len_i(burst_len_i),
        .seed_data_i(seed_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o), .cmd_v_o(cmd_v_o),
        .cmd_ready_and_i(cmd_ready_and_i), .resp_v_i(resp_v_i), .resp_yumi_o(resp_yumi_o),
        .in_cmd_v_i(in_cmd_v_i), .in_cmd_wr_i(in_cmd_wr_i), .in_cmd_addr_i(in_cmd_addr_i),
        .in_cmd_data_i(in_cmd_data_i), .in_cmd_yumi_o(in_cmd_yumi_o), .in_resp_v_o(in_resp_v_o),
        .in_resp_data_o(in_resp_data_o), .in_resp_ready_and_i(in_resp_ready_and_i)
    );

    bp_io_traffic_gen #(.addr_stride_p(40'h8)) dut_s (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .burst_len_i(burst_len_i),
        .seed_data_i(seed_data_i), .busy_o(busy_s), .done_o(done_s), .err_o(err_s),
        .cmd_addr_o(cmd_addr_s), .cmd_data_o(cmd_data_s), .cmd_v_o(cmd_v_s),
        .cmd_ready_and_i(cmd_ready_and_i), .resp_v_i(resp_v_i), .resp_yumi_o(resp_yumi_s),
        .in_cmd_v_i(in_cmd_v_i), .in_cmd_wr_i(in_cmd_wr_i), .in_cmd_addr_i(in_cmd_addr_i),
        .in_cmd_data_i(in_cmd_data_i), .in_cmd_yumi_o(in_cmd_yumi_s), .in_resp_v_o(in_resp_v_s),
        .in_resp_data_o(in_resp_data_s), .in_resp_ready_and_i(in_resp_ready_and_i)
    );

    int          n_chk = 0, n_err = 0;
    bit          m_active, m_err;
    int          m_len, m_sent, m_outst, m_dones;
    logic [63:0] m_seed;
    bit          due [0:127];
    logic        hs;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // One generator cycle: drive, check combinational outputs, advance the model, check registers.
    task automatic cyc(input logic st, input logic rdy, input logic rsp, output logic hs_o);
        bit pre_active, exp_done;
        int pre_outst, pre_sent;
        start_i = st; cmd_ready_and_i = rdy; resp_v_i = rsp;
        #1;
        chk("cmd_v", cmd_v_o, (m_active && m_sent < m_len && m_outst < MAX));
        chk("resp_yumi", resp_yumi_o, rsp);
        if (cmd_v_o) begin
            chk("addr", cmd_addr_o, BASE);
            chk("addr_stride", cmd_addr_s, BASE + 64'(8 * m_sent));
            chk("data", cmd_data_o, m_seed + 64'(m_sent));
        end
        hs_o = cmd_v_o && rdy;
        pre_active = m_active; pre_outst = m_outst; pre_sent = m_sent; exp_done = 0;
        if (rsp && pre_outst == 0) m_err = 1;
        m_outst = pre_outst + (hs_o ? 1 : 0) - ((rsp && pre_outst > 0) ? 1 : 0);
        if (hs_o) m_sent++;
        if (pre_active && pre_sent == m_len && m_outst == 0) begin
            exp_done = 1; m_active = 0;
        end
        if (st && !pre_active) begin
            if (burst_len_i == 0) exp_done = 1;
            else begin
                m_active = 1; m_len = int'(burst_len_i); m_seed = seed_data_i; m_sent = 0;
            end
        end
        @(posedge clk); #2;
        start_i = 1'b0;
        chk("done", done_o, exp_done);
        chk("busy", busy_o, m_active);
        chk("err", err_o, m_err);
        if (done_o) m_dones++;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; start_i = 0; cmd_ready_and_i = 0; resp_v_i = 0;
        in_cmd_v_i = 0; in_resp_ready_and_i = 0;
        @(posedge clk); #2;
        reset_i = 1'b0;
        m_active = 0; m_err = 0; m_len = 0; m_sent = 0; m_outst = 0;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cmd_v", cmd_v_o, 0);
        chk("rst_in_resp_v", in_resp_v_o, 0);
    endtask

    // Burst with responses returned lat cycles after each handshake; rnd adds ready stalls.
    task automatic run_burst(input int len, input logic [63:0] seed, input int lat, input bit rnd);
        logic rdy, h;
        foreach (due[i]) due[i] = 0;
        burst_len_i = 16'(len); seed_data_i = seed; m_dones = 0;
        for (int k = 0; k < 100 && (k == 0 || m_active); k++) begin
            rdy = !rnd ? 1'b1 : (k == 1) ? 1'b0 : (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc(k == 0 || k == 2, rdy, due[k], h);
            if (h) due[k + lat] = 1;
        end
        chk("burst_timeout", m_active, 0);
        chk("burst_sent", m_sent, len);
        chk("burst_dones", m_dones, 1);
    endtask

    task automatic lb(input logic v, input logic wr, input logic [39:0] a, input logic [63:0] d,
                      input logic rdy, input logic exp_yumi);
        in_cmd_v_i = v; in_cmd_wr_i = wr; in_cmd_addr_i = a; in_cmd_data_i = d;
        in_resp_ready_and_i = rdy;
        #1;
        chk("in_yumi", in_cmd_yumi_o, exp_yumi);
        @(posedge clk); #2;
    endtask

    initial begin
        do_reset();

        // 1: fixed address, responses 3 cycles after each command, a start while busy
        run_burst(5, 64'h41, 3, 0);
        cyc(0, 1, 0, hs);

        // 2: responses withheld -> cap at MAX outstanding, then one command per response
        burst_len_i = 16'd10; seed_data_i = 64'h200; m_dones = 0;
        for (int k = 0; k < 8; k++) cyc(k == 0, 1, 0, hs);
        chk("t2_sent_cap", m_sent, 4);
        chk("t2_cmd_v_low", cmd_v_o, 0);
        for (int k = 0; k < 60 && m_active; k++) cyc(0, 1, (k % 3) == 0, hs);
        chk("t2_timeout", m_active, 0);
        chk("t2_sent", m_sent, 10);
        chk("t2_dones", m_dones, 1);

        // 3: strided addresses with ready stalls
        run_burst(3, 64'h300, 2, 1);

        // 4: unexpected response sets sticky err; zero-length start pulses done only
        cyc(0, 0, 1, hs);
        chk("t4_err_set", err_o, 1);
        run_burst(2, 64'h400, 1, 0);
        chk("t4_err_sticky", err_o, 1);
        burst_len_i = 16'd0;
        cyc(1, 1, 0, hs);
        cyc(0, 1, 0, hs);

        // 5: loopback responder
        lb(1, 1, 40'h10, 64'hDEAD, 1, 1);
        chk("lb_wr_v", in_resp_v_o, 1);   chk("lb_wr_d", in_resp_data_o, 64'hDEAD);
        lb(1, 0, 40'h10, 64'h0, 1, 1);
        chk("lb_rd_v", in_resp_v_o, 1);   chk("lb_rd_d", in_resp_data_o, 64'hDEAD);
        lb(1, 1, 40'h18, 64'hBEEF, 0, 0);
        chk("lb_hold_v", in_resp_v_o, 1); chk("lb_hold_d", in_resp_data_o, 64'hDEAD);
        lb(1, 1, 40'h18, 64'hBEEF, 1, 1);
        chk("lb_wr2_d", in_resp_data_o, 64'hBEEF);
        lb(1, 0, 40'h18, 64'h0, 1, 1);
        chk("lb_rd2_d", in_resp_data_o, 64'hBEEF);
        lb(1, 0, 40'h50, 64'h0, 1, 1);
        chk("lb_alias_d", in_resp_data_o, 64'hDEAD);
        lb(1, 0, 40'h08, 64'h0, 1, 1);
        chk("lb_empty_d", in_resp_data_o, 64'h0);
        lb(0, 0, 40'h0, 64'h0, 1, 0);
        chk("lb_drain_v", in_resp_v_o, 0);

        // 6: reset mid-burst with 2 outstanding, then a clean burst from base
        burst_len_i = 16'd6; seed_data_i = 64'h600; m_dones = 0;
        for (int k = 0; k < 3; k++) cyc(k == 0, 1, 0, hs);
        chk("t6_outst", m_outst, 2);
        do_reset();
        cyc(0, 1, 0, hs);
        chk("t6_no_done", m_dones, 0);
        lb(1, 0, 40'h10, 64'h0, 1, 1);
        chk("t6_scratch_clr", in_resp_data_o, 64'h0);
        lb(0, 0, 40'h0, 64'h0, 1, 0);
        run_burst(2, 64'h700, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
